// File: rtl/cam_controller.sv
// Request-side CAM controller: decodes writes into one-hot row enables, drives the
// search key/mask, and serialises each match vector into one beat per matching row.
module cam_controller #(
   parameter int CAM_WIDTH  = 8,
   parameter int CAM_DEPTH  = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [CAM_WIDTH-1:0]  req_word,
   input  logic [CAM_WIDTH-1:0]  req_mask,
   output logic [CAM_DEPTH-1:0]  cam_we,
   output logic [CAM_WIDTH-1:0]  cam_search_word,
   output logic [CAM_WIDTH-1:0]  cam_dont_care_mask,
   input  logic [CAM_DEPTH-1:0]  cam_match,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_hit,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic                  rsp_last,
   output logic [ADDR_WIDTH:0]   rsp_count
);

   typedef enum logic [1:0] {IDLE, WRITE, SEARCH, EMIT} state_t;

   state_t                state, state_next;
   logic [CAM_DEPTH-1:0]  match_vec, match_next, remaining;
   logic [CAM_DEPTH-1:0]  cam_we_next;
   logic [CAM_WIDTH-1:0]  word_next, mask_next;
   logic                  req_ready_next, rsp_valid_next, rsp_hit_next, rsp_last_next;
   logic [ADDR_WIDTH-1:0] rsp_addr_next;
   logic [ADDR_WIDTH:0]   rsp_count_next;

   // Addresses at or beyond CAM_DEPTH decode to no row at all.
   function automatic logic [CAM_DEPTH-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      decode = '0;
      for (int i = 0; i < CAM_DEPTH; i++)
         if (addr == ADDR_WIDTH'(i)) decode[i] = 1'b1;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] lowest_index(input logic [CAM_DEPTH-1:0] vec);
      lowest_index = '0;
      for (int i = CAM_DEPTH - 1; i >= 0; i--)
         if (vec[i]) lowest_index = ADDR_WIDTH'(i);
   endfunction

   function automatic logic [ADDR_WIDTH:0] popcount(input logic [CAM_DEPTH-1:0] vec);
      popcount = '0;
      for (int i = 0; i < CAM_DEPTH; i++)
         popcount = popcount + {{ADDR_WIDTH{1'b0}}, vec[i]};
   endfunction

   function automatic logic single_bit(input logic [CAM_DEPTH-1:0] vec);
      single_bit = (vec != '0) && ((vec & (vec - CAM_DEPTH'(1))) == '0);
   endfunction

   always_comb begin
      // NOTE: every value written here gets a default first, so no latch is inferred.
      state_next     = state;
      req_ready_next = req_ready;
      cam_we_next    = '0;
      word_next      = cam_search_word;
      mask_next      = cam_dont_care_mask;
      match_next     = match_vec;
      remaining      = match_vec;
      rsp_valid_next = rsp_valid;
      rsp_hit_next   = rsp_hit;
      rsp_addr_next  = rsp_addr;
      rsp_last_next  = rsp_last;
      rsp_count_next = rsp_count;

      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               word_next      = req_word;
               req_ready_next = 1'b0;
               if (req_write) begin
                  mask_next   = '0;
                  cam_we_next = decode(req_addr);
                  state_next  = WRITE;
               end else begin
                  mask_next  = req_mask;
                  state_next = SEARCH;
               end
            end
         end
         WRITE: begin
            req_ready_next = 1'b1;
            state_next     = IDLE;
         end
         SEARCH: begin
            // The first beat is formed straight from the array's answer so it is ready next cycle.
            match_next     = cam_match;
            rsp_valid_next = 1'b1;
            rsp_hit_next   = (cam_match != '0);
            rsp_addr_next  = lowest_index(cam_match);
            rsp_last_next  = (cam_match == '0) || single_bit(cam_match);
            rsp_count_next = popcount(cam_match);
            state_next     = EMIT;
         end
         EMIT: begin
            if (rsp_ready) begin
               remaining  = match_vec & ~decode(rsp_addr);
               match_next = remaining;
               if (rsp_last) begin
                  rsp_valid_next = 1'b0;
                  req_ready_next = 1'b1;
                  state_next     = IDLE;
               end else begin
                  rsp_addr_next = lowest_index(remaining);
                  rsp_last_next = single_bit(remaining);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state              <= IDLE;
         req_ready          <= 1'b1;
         cam_we             <= '0;
         cam_search_word    <= '0;
         cam_dont_care_mask <= '0;
         match_vec          <= '0;
         rsp_valid          <= 1'b0;
         rsp_hit            <= 1'b0;
         rsp_addr           <= '0;
         rsp_last           <= 1'b0;
         rsp_count          <= '0;
      end else begin
         state              <= state_next;
         req_ready          <= req_ready_next;
         cam_we             <= cam_we_next;
         cam_search_word    <= word_next;
         cam_dont_care_mask <= mask_next;
         match_vec          <= match_next;
         rsp_valid          <= rsp_valid_next;
         rsp_hit            <= rsp_hit_next;
         rsp_addr           <= rsp_addr_next;
         rsp_last           <= rsp_last_next;
         rsp_count          <= rsp_count_next;
      end
   end

endmodule

// File: tb/tb_cam_controller.sv
// Bench for cam_controller: behavioural CAM array, row-content reference model and a
// response scoreboard drained by an independent monitor; a depth-3 instance covers dropped writes.
module tb_cam_controller;

   localparam int W = 8;
   localparam int D = 4;
   localparam int A = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance (depth 4)
   logic         req_valid = 1'b0, req_write = 1'b0;
   logic [A-1:0] req_addr = '0;
   logic [W-1:0] req_word = '0, req_mask = '0;
   logic         req_ready;
   logic [D-1:0] cam_we, cam_match;
   logic [W-1:0] cam_search_word, cam_dont_care_mask;
   logic         rsp_valid, rsp_hit, rsp_last;
   logic         rsp_ready = 1'b1;
   logic [A-1:0] rsp_addr;
   logic [A:0]   rsp_count;

   cam_controller #(.CAM_WIDTH(W), .CAM_DEPTH(D), .ADDR_WIDTH(A)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_word(req_word), .req_mask(req_mask),
      .cam_we(cam_we), .cam_search_word(cam_search_word),
      .cam_dont_care_mask(cam_dont_care_mask), .cam_match(cam_match),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
      .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_count(rsp_count)
   );

   // depth-3 instance
   logic         req_valid_3 = 1'b0, req_write_3 = 1'b0;
   logic [1:0]   req_addr_3 = '0;
   logic [W-1:0] req_word_3 = '0, req_mask_3 = '0;
   logic         req_ready_3;
   logic [2:0]   cam_we_3, cam_match_3;
   logic [W-1:0] cam_search_word_3, cam_dont_care_mask_3;
   logic         rsp_valid_3, rsp_hit_3, rsp_last_3;
   logic         rsp_ready_3 = 1'b1;
   logic [1:0]   rsp_addr_3;
   logic [2:0]   rsp_count_3;

   cam_controller #(.CAM_WIDTH(W), .CAM_DEPTH(3), .ADDR_WIDTH(2)) dut3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_3), .req_ready(req_ready_3), .req_write(req_write_3),
      .req_addr(req_addr_3), .req_word(req_word_3), .req_mask(req_mask_3),
      .cam_we(cam_we_3), .cam_search_word(cam_search_word_3),
      .cam_dont_care_mask(cam_dont_care_mask_3), .cam_match(cam_match_3),
      .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_hit(rsp_hit_3),
      .rsp_addr(rsp_addr_3), .rsp_last(rsp_last_3), .rsp_count(rsp_count_3)
   );

   // behavioural CAM arrays driven by the DUTs' write enables
   logic [W-1:0] arr [D];
   bit           arr_v [D];
   logic [W-1:0] arr3 [3];
   bit           arr3_v [3];

   always @(posedge clk) begin
      for (int i = 0; i < D; i++)
         if (cam_we[i]) begin arr[i] <= cam_search_word; arr_v[i] <= 1'b1; end
      for (int i = 0; i < 3; i++)
         if (cam_we_3[i]) begin arr3[i] <= cam_search_word_3; arr3_v[i] <= 1'b1; end
   end

   always_comb begin
      cam_match = '0;
      for (int i = 0; i < D; i++)
         cam_match[i] = arr_v[i] && (((arr[i] ^ cam_search_word) & ~cam_dont_care_mask) == '0);
   end

   always_comb begin
      cam_match_3 = '0;
      for (int i = 0; i < 3; i++)
         cam_match_3[i] = arr3_v[i] && (((arr3[i] ^ cam_search_word_3) & ~cam_dont_care_mask_3) == '0);
   end

   // reference model: what each row should hold, from the writes the bench issued
   logic [W-1:0] ref_word [D];
   bit           ref_used [D];

   typedef struct {
      logic         hit;
      logic [A-1:0] addr;
      logic         last;
      logic [A:0]   count;
      int           first_cyc;
   } beat_t;

   beat_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   bit rand_ready = 1'b0;
   int hold_beat = -1;
   int hold_left = 0;
   int beat_idx = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_state(input string name);
      check(name, {rsp_valid, rsp_hit, rsp_addr, rsp_last, rsp_count, cam_we, cam_search_word, cam_dont_care_mask},
            {1'b0, 1'b0, {A{1'b0}}, 1'b0, {(A+1){1'b0}}, {D{1'b0}}, {W{1'b0}}, {W{1'b0}}});
   endtask

   // drive one request from a negedge; returns the cycle number seen one negedge after acceptance
   task automatic issue(input logic wr, input logic [A-1:0] addr, input logic [W-1:0] word,
                        input logic [W-1:0] mask, output int acc);
      int waited;
      waited    = 0;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_word  = word;
      req_mask  = mask;
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) check("req_accept_wait", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      acc       = cyc;
      req_valid = 1'b0;
   endtask

   task automatic do_write(input logic [A-1:0] addr, input logic [W-1:0] word);
      int           acc;
      logic [D-1:0] exp_we;
      issue(1'b1, addr, word, 8'hC3, acc);
      exp_we       = '0;
      exp_we[addr] = 1'b1;
      check("write_pulse", {cam_we, cam_search_word, cam_dont_care_mask}, {exp_we, word, 8'h00});
      ref_word[addr] = word;
      ref_used[addr] = 1'b1;
      @(negedge clk);
      check("write_end_ready", {cam_we, req_ready}, {{D{1'b0}}, 1'b1});
   endtask

   task automatic do_search(input logic [W-1:0] key, input logic [W-1:0] mask);
      int    acc;
      int    hits[$];
      beat_t b;
      issue(1'b0, 2'd3, key, mask, acc);
      check("search_bus", {cam_we, cam_search_word, cam_dont_care_mask}, {{D{1'b0}}, key, mask});
      for (int r = 0; r < D; r++)
         if (ref_used[r] && (((ref_word[r] ^ key) & ~mask) == '0)) hits.push_back(r);
      if (hits.size() == 0) begin
         b.hit = 1'b0; b.addr = '0; b.last = 1'b1; b.count = '0; b.first_cyc = acc + 1;
         exp_q.push_back(b);
      end else begin
         foreach (hits[i]) begin
            b.hit       = 1'b1;
            b.addr      = A'(hits[i]);
            b.last      = (i == hits.size() - 1);
            b.count     = (A+1)'(hits.size());
            b.first_cyc = (i == 0) ? acc + 1 : -1;
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic issue3(input logic wr, input logic [1:0] addr, input logic [W-1:0] word);
      int waited;
      waited      = 0;
      req_valid_3 = 1'b1;
      req_write_3 = wr;
      req_addr_3  = addr;
      req_word_3  = word;
      req_mask_3  = 8'h00;
      while (!req_ready_3 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready_3) check("d3_accept_wait", req_ready_3, 1);
      @(posedge clk);
      @(negedge clk);
      req_valid_3 = 1'b0;
   endtask

   // monitor: drives rsp_ready, then checks stability, first-beat timing and beat contents
   initial begin
      bit                   stalled, prev_valid, ready_due;
      logic [2*A+2:0]       prev;
      beat_t                e;
      stalled = 0; prev_valid = 0; ready_due = 0; prev = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            beat_idx   = 0;
            stalled    = 0;
            prev_valid = 0;
            ready_due  = 0;
            continue;
         end
         if (hold_left > 0 && rsp_valid && beat_idx == hold_beat) begin
            rsp_ready = 1'b0;
            hold_left--;
         end else begin
            rsp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         if (ready_due) begin
            check("req_ready_after_last", req_ready, 1);
            ready_due = 0;
         end
         if (stalled)
            check("rsp_stable", {rsp_valid, rsp_hit, rsp_addr, rsp_last, rsp_count}, {1'b1, prev});
         if (rsp_valid && !prev_valid && exp_q.size() != 0)
            check("first_beat_cycle", 64'(cyc), 64'(exp_q[0].first_cyc));
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {rsp_hit, rsp_addr, rsp_last, rsp_count}, 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("beat", {rsp_hit, rsp_addr, rsp_last, rsp_count}, {e.hit, e.addr, e.last, e.count});
               beat_idx++;
               if (e.last) begin
                  beat_idx  = 0;
                  ready_due = 1;
               end
            end
         end
         stalled    = rsp_valid && !rsp_ready;
         prev       = {rsp_hit, rsp_addr, rsp_last, rsp_count};
         prev_valid = rsp_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   waited;
      logic [W-1:0] m;

      // reset and its output values
      #1 rst = 1'b0;
      #20 check_reset_state("in_reset");
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check_reset_state("after_reset");
      check("ready_after_reset", req_ready, 1);

      // single write, no response expected
      do_write(2'd2, 8'hA5);

      // unique hit
      do_write(2'd0, 8'h11); do_write(2'd1, 8'h22); do_write(2'd2, 8'h33); do_write(2'd3, 8'h44);
      do_search(8'h33, 8'h00);

      // three masked hits with a three-cycle stall on the second beat
      do_write(2'd0, 8'h10); do_write(2'd1, 8'h1F); do_write(2'd2, 8'h20); do_write(2'd3, 8'h15);
      hold_beat = 1;
      hold_left = 3;
      do_search(8'h10, 8'h0F);

      // miss
      do_search(8'hFF, 8'h00);

      // write immediately followed by a search of the same word
      do_write(2'd1, 8'h77);
      do_search(8'h77, 8'h00);

      // reset during the second beat of a three-match search
      do_write(2'd1, 8'h1F);
      do_search(8'h10, 8'h0F);
      waited = 0;
      while (beat_idx != 1 && waited < 20) begin
         @(negedge clk);
         #1 waited++;
      end
      check("second_beat_reached", 64'(beat_idx), 64'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check("reset_mid_emit", {rsp_valid, cam_we}, {1'b0, {D{1'b0}}});
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_state("after_mid_reset");
      check("ready_after_mid_reset", req_ready, 1);
      do_search(8'h10, 8'h00);

      // randomized traffic with random back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 4) begin
            do_write(A'($urandom_range(0, D - 1)), 8'h30 | 8'($urandom_range(0, 15)));
         end else begin
            case ($urandom_range(0, 3))
               0:       m = 8'h00;
               1:       m = 8'h03;
               2:       m = 8'h0F;
               default: m = 8'hFF;
            endcase
            do_search(8'h30 | 8'($urandom_range(0, 15)), m);
         end
      end
      waited = 0;
      while ((exp_q.size() != 0 || !req_ready) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

      // depth-3 instance: out-of-range write is dropped
      issue3(1'b1, 2'd0, 8'h11);
      check("d3_we_row0", cam_we_3, 3'b001);
      issue3(1'b1, 2'd3, 8'h5A);
      check("d3_we_addr3", cam_we_3, 3'b000);
      @(negedge clk);
      check("d3_we_addr3_after", cam_we_3, 3'b000);
      issue3(1'b0, 2'd0, 8'h5A);
      @(negedge clk);
      check("d3_miss", {rsp_valid_3, rsp_hit_3, rsp_addr_3, rsp_last_3, rsp_count_3},
            {1'b1, 1'b0, 2'd0, 1'b1, 3'd0});
      issue3(1'b0, 2'd0, 8'h11);
      @(negedge clk);
      check("d3_hit", {rsp_valid_3, rsp_hit_3, rsp_addr_3, rsp_last_3, rsp_count_3},
            {1'b1, 1'b1, 2'd0, 1'b1, 3'd1});
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cam_controller.md
# cam_controller

Request-side controller for the CAM array. Accepts binary-addressed write and search requests over a valid/ready handshake, and generates the one-hot row write enables plus the search word and don't-care mask. It captures the one-hot match vector returned by the array and emits one response beat per matching row, lowest row first, over a second valid/ready handshake. It sits between the lookup client and the CAM array and owns all address decoding and match encoding.

## Interface
- CAM_WIDTH, 8, width of a stored word / search word
- CAM_DEPTH, 4, number of CAM rows
- ADDR_WIDTH, 2, row address width; must satisfy 2^ADDR_WIDTH >= CAM_DEPTH
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write req_word to row req_addr; 0 = search
- req_addr  in  ADDR_WIDTH  target row for writes; ignored for searches
- req_word  in  CAM_WIDTH  write data or search key
- req_mask  in  CAM_WIDTH  search don't-care mask, bit=1 ignores that bit; ignored for writes
- cam_we  out  CAM_DEPTH  one-hot row write enable to the array
- cam_search_word  out  CAM_WIDTH  write data / search key to the array
- cam_dont_care_mask  out  CAM_WIDTH  mask to the array
- cam_match  in  CAM_DEPTH  one-hot/multi-hot match vector from the array
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  client accepts beat
- rsp_hit  out  1  1 = rsp_addr is a matching row; 0 = search missed
- rsp_addr  out  ADDR_WIDTH  matching row index
- rsp_last  out  1  final beat of this search
- rsp_count  out  ADDR_WIDTH+1  total matches of this search, constant across its beats

## Operation
- FSM states: IDLE, WRITE, SEARCH, EMIT. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, latch req_word into cam_search_word. For a write, latch req_addr, drive cam_dont_care_mask to all zeros, go WRITE. For a search, latch req_mask into cam_dont_care_mask, go SEARCH.
- WRITE: cam_we = one-hot decode of the latched address for exactly this cycle, then IDLE. If address >= CAM_DEPTH, cam_we stays all zeros (write dropped silently, no error). Writes produce no response.
- SEARCH: word and mask held on the CAM bus. cam_match registered into match_vec at the end of the cycle. Popcount registered into rsp_count. Go EMIT.
- EMIT, match_vec != 0: rsp_valid=1, rsp_hit=1, rsp_addr = index of lowest set bit, rsp_last = (exactly one bit set). On rsp_ready, clear that bit. If rsp_last, go IDLE.
- EMIT, match_vec == 0: single beat with rsp_hit=0, rsp_addr=0, rsp_last=1, rsp_count=0. Go IDLE on rsp_ready.
- cam_match bits at index >= CAM_DEPTH do not exist; match_vec is exactly CAM_DEPTH bits.
- req_ready=0 in WRITE, SEARCH and EMIT. There is no request queueing.
- rsp_addr, rsp_hit, rsp_last and rsp_count must stay stable while rsp_valid=1 and rsp_ready=0.
- cam_search_word and cam_dont_care_mask hold their last latched values in IDLE.

## Timing
- Reset (asynchronous, immediate): state=IDLE; cam_we=0; cam_search_word=0; cam_dont_care_mask=0; match_vec=0; rsp_valid=0, rsp_hit=0, rsp_addr=0, rsp_last=0, rsp_count=0; req_ready=1 after rst deasserts.
- Reset mid-WRITE: cam_we drops to 0 asynchronously, so no partial write pulse extends past reset. Reset mid-EMIT: pending beats are discarded.
- Write accepted at cycle N: cam_we asserted in cycle N+1 only; req_ready=1 again in cycle N+2.
- Search accepted at cycle N: key and mask on the CAM bus from N+1; cam_match sampled at the end of N+1. The array must produce a valid match combinationally within one cycle of a stable key.
- First beat rsp_valid=1 in cycle N+2. With rsp_ready held high, k matches take k cycles (N+2..N+k+1); req_ready=1 in N+k+2.
- Write followed immediately by a search of the same word: the search sees the written row, because the write completes in WRITE before the search is accepted.
- All outputs are registered; no combinational path from req_* or rsp_ready to any output.

## Test plan
- Reset, then write 0xA5 to row 2 -> cam_we=4'b0100 for exactly one cycle, 1 cycle after acceptance; no rsp_valid.
- Rows 0..3 = 0x11,0x22,0x33,0x44; search 0x33 with mask 0x00 -> one beat: hit=1, addr=2, last=1, count=1, at acceptance+2.
- Rows 0..3 = 0x10,0x1F,0x20,0x15; search 0x10 with mask 0x0F -> beats addr=0, 1, 3 in that order, count=3, last only on addr=3. Holding rsp_ready=0 for 3 cycles on beat 2 keeps addr=1 stable.
- Search 0xFF against the same contents, mask 0x00 -> one beat: hit=0, addr=0, last=1, count=0. req_ready returns high the cycle after acceptance of that beat.
- With CAM_DEPTH=3, ADDR_WIDTH=2, write to address 3 -> cam_we stays 0; a later search of that word misses.
- Assert rst low during the second beat of a 3-match search -> rsp_valid=0 and cam_we=0 immediately; after release, req_ready=1 and a new search of row 0's word returns addr=0.
